// File: rtl/battleship_pkg.sv
// Shared types, constants and cell helpers for the battleship attack logic.
// Contents: cell code enum, resolver state enum, board geometry constants,
// turn timeout length, LFSR taps/seed and small board access helpers.
package battleship_pkg;

  localparam int BOARD_N       = 5;
  localparam int CELLS         = 25;
  localparam int TIMEOUT_TICKS = 10;

  // x^5 + x^3 + 1 : feedback taken from bits 4 and 2 of a left-shifting register
  localparam logic [4:0] LFSR_TAPS = 5'b10100;
  localparam logic [4:0] LFSR_SEED = 5'b00001;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SHIP  = 2'b01,
    MISS  = 2'b10,
    HIT   = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_P,
    RES_P,
    PICK_PC,
    RES_PC,
    DONE
  } state_t;

  function automatic cell_t cell_at(input logic [49:0] b, input logic [4:0] k);
    logic [49:0] s;
    s = b >> {k, 1'b0};
    return cell_t'(s[1:0]);
  endfunction

  function automatic logic [49:0] set_cell(input logic [49:0] b, input logic [4:0] k,
                                           input cell_t c);
    logic [49:0] m;
    logic [49:0] v;
    m = 50'd3 << {k, 1'b0};
    v = {48'd0, c} << {k, 1'b0};
    return (b & ~m) | v;
  endfunction

  // MISS and HIT both have the upper bit set
  function automatic logic is_shot(input cell_t c);
    return c[1];
  endfunction

  function automatic cell_t resolve(input cell_t c);
    case (c)
      SHIP:    return HIT;
      EMPTY:   return MISS;
      default: return c;
    endcase
  endfunction

endpackage

// File: rtl/attack_resolver_if.sv
// Bus between the game controller and attack_resolver.
// master: game side (drives load, boards in, turns, fire, cursor, tick).
// slave : resolver side (drives resolved boards, ship counts and pulses).
interface attack_resolver_if;
  logic        load;
  logic [49:0] board_player_in;
  logic [49:0] board_pc_in;
  logic        player_turn;
  logic        pc_turn;
  logic        player_move;
  logic [2:0]  i_actual;
  logic [2:0]  j_actual;
  logic        tick;
  logic [49:0] board_player;
  logic [49:0] board_pc;
  logic [4:0]  player_ships;
  logic [4:0]  pc_ships;
  logic        shot_hit;
  logic        turn_done;
  logic        time_expired;

  modport master (
    output load, board_player_in, board_pc_in, player_turn, pc_turn, player_move,
           i_actual, j_actual, tick,
    input  board_player, board_pc, player_ships, pc_ships, shot_hit, turn_done,
           time_expired
  );

  modport slave (
    input  load, board_player_in, board_pc_in, player_turn, pc_turn, player_move,
           i_actual, j_actual, tick,
    output board_player, board_pc, player_ships, pc_ships, shot_hit, turn_done,
           time_expired
  );
endinterface

// File: rtl/ship_counter.sv
// Combinational count of SHIP cells on a 25-cell board.
// Ports: board (50-bit, 2 bits per cell) in, count (0..25) out.
module ship_counter
  import battleship_pkg::*;
(
  input  logic [49:0] board,
  output logic [4:0]  count
);

  always_comb begin
    count = '0;
    for (int k = 0; k < CELLS; k++) begin
      if (board[2*k +: 2] == SHIP) count = count + 5'd1;
    end
  end

endmodule

// File: rtl/attack_resolver.sv
// Resolves player and computer shots on two 5x5 battleship boards.
// Ports: clk, rst (async active-low), bus (attack_resolver_if.slave).
// Optional: TURN_TIMEOUT_EN adds an automatic player fire after TIMEOUT_TICKS
// ticks of inactivity in WAIT_P; without it time_expired is 0 and tick is unused.
//
// state   | meaning
// IDLE    | waiting for a turn request
// WAIT_P  | player turn, waiting for a fire edge
// RES_P   | resolve the player shot on the pc board
// PICK_PC | probe for an unshot cell on the player board
// RES_PC  | resolve the computer shot on the player board
// DONE    | turn finished, wait for both turn levels to drop
module attack_resolver
  import battleship_pkg::*;
(
  input logic clk,
  input logic rst,
  attack_resolver_if.slave bus
);

  state_t      state, state_next;
  logic [49:0] board_player, board_pc;
  logic [4:0]  player_ships, pc_ships;
  logic [4:0]  player_cnt, pc_cnt;
  logic [4:0]  idx, idx_next;
  logic [4:0]  probe, probe_next;
  logic [4:0]  lfsr;
  logic [4:0]  cur_idx;
  logic        move_q, move_rise, in_range;
  logic        wr_player, wr_pc, hit_next, done_next;
  logic        shot_hit, turn_done;
  cell_t       cell_pc, cell_pl;
`ifdef TURN_TIMEOUT_EN
  logic [3:0]  tick_cnt, tick_next;
  logic        expire_next, time_expired;
`endif

  ship_counter u_cnt_player (.board(bus.board_player_in), .count(player_cnt));
  ship_counter u_cnt_pc     (.board(bus.board_pc_in),     .count(pc_cnt));

  assign move_rise = bus.player_move & ~move_q;
  assign in_range  = (bus.i_actual < 3'(BOARD_N)) && (bus.j_actual < 3'(BOARD_N));
  assign cur_idx   = 5'(bus.i_actual) * 5'(BOARD_N) + 5'(bus.j_actual);
  assign cell_pc   = cell_at(board_pc, idx);
  assign cell_pl   = cell_at(board_player, idx);

  // LFSR and fire edge detector run every cycle regardless of load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr   <= LFSR_SEED;
      move_q <= 1'b0;
    end else begin
      lfsr   <= {lfsr[3:0], ^(lfsr & LFSR_TAPS)};
      move_q <= bus.player_move;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          state <= IDLE;
    else if (bus.load) state <= IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    probe_next = probe;
    wr_player  = 1'b0;
    wr_pc      = 1'b0;
    hit_next   = 1'b0;
    done_next  = 1'b0;
`ifdef TURN_TIMEOUT_EN
    tick_next   = tick_cnt;
    expire_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.player_turn) begin
          state_next = WAIT_P;
`ifdef TURN_TIMEOUT_EN
          tick_next = 4'(TIMEOUT_TICKS);
`endif
        end else if (bus.pc_turn) begin
          state_next = PICK_PC;
          idx_next   = (lfsr < 5'(CELLS)) ? lfsr : lfsr - 5'(CELLS);
          probe_next = '0;
        end
      end
      WAIT_P: begin
        if (move_rise && in_range) begin
          state_next = RES_P;
          idx_next   = cur_idx;
        end
`ifdef TURN_TIMEOUT_EN
        // down-counter: the tick that reaches terminal count fires the shot
        else if (bus.tick) begin
          if (tick_cnt == 4'd1) begin
            state_next  = RES_P;
            idx_next    = in_range ? cur_idx : 5'd0;
            expire_next = 1'b1;
          end else begin
            tick_next = tick_cnt - 4'd1;
          end
        end
`endif
      end
      RES_P: begin
        if (is_shot(cell_pc)) begin
          // repeated shot: player must fire again, no turn end
          state_next = WAIT_P;
`ifdef TURN_TIMEOUT_EN
          tick_next = 4'(TIMEOUT_TICKS);
`endif
        end else begin
          wr_pc      = 1'b1;
          hit_next   = (cell_pc == SHIP);
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      PICK_PC: begin
        if (is_shot(cell_pl)) begin
          if (probe == 5'(CELLS - 1)) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            idx_next   = (idx == 5'(CELLS - 1)) ? 5'd0 : idx + 5'd1;
            probe_next = probe + 5'd1;
          end
        end else begin
          state_next = RES_PC;
        end
      end
      RES_PC: begin
        wr_player  = !is_shot(cell_pl);
        hit_next   = (cell_pl == SHIP);
        done_next  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (!bus.player_turn && !bus.pc_turn) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board_player <= '0;
      board_pc     <= '0;
      player_ships <= '0;
      pc_ships     <= '0;
      idx          <= '0;
      probe        <= '0;
      shot_hit     <= 1'b0;
      turn_done    <= 1'b0;
    end else if (bus.load) begin
      board_player <= bus.board_player_in;
      board_pc     <= bus.board_pc_in;
      player_ships <= player_cnt;
      pc_ships     <= pc_cnt;
      idx          <= '0;
      probe        <= '0;
      shot_hit     <= 1'b0;
      turn_done    <= 1'b0;
    end else begin
      idx       <= idx_next;
      probe     <= probe_next;
      shot_hit  <= hit_next;
      turn_done <= done_next;
      if (wr_pc) begin
        board_pc <= set_cell(board_pc, idx, resolve(cell_pc));
        if (hit_next && pc_ships != 5'd0) pc_ships <= pc_ships - 5'd1;
      end
      if (wr_player) begin
        board_player <= set_cell(board_player, idx, resolve(cell_pl));
        if (hit_next && player_ships != 5'd0) player_ships <= player_ships - 5'd1;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt     <= 4'(TIMEOUT_TICKS);
      time_expired <= 1'b0;
    end else if (bus.load) begin
      tick_cnt     <= 4'(TIMEOUT_TICKS);
      time_expired <= 1'b0;
    end else begin
      tick_cnt     <= tick_next;
      time_expired <= expire_next;
    end
  end
  assign bus.time_expired = time_expired;
`else
  logic unused_tick;
  assign unused_tick      = bus.tick;
  assign bus.time_expired = 1'b0;
`endif

  assign bus.board_player = board_player;
  assign bus.board_pc     = board_pc;
  assign bus.player_ships = player_ships;
  assign bus.pc_ships     = pc_ships;
  assign bus.shot_hit     = shot_hit;
  assign bus.turn_done    = turn_done;

endmodule

// File: doc/attack_resolver.md
ATTACK_RESOLVER -- requirements
Module: attack_resolver

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port load  input  1  one-cycle pulse: copy both boards and recount ships.
REQ-004 SHALL have port board_player_in / board_pc_in  input  50 each  25 cells x 2 bits, cell k = row*5+col.
REQ-005 SHALL have port player_turn / pc_turn  input  1 each  turn levels from the game FSM.
REQ-006 SHALL have port player_move  input  1  fire request level; rising edge is the fire event.
REQ-007 SHALL have port i_actual / j_actual  input  3 each  cursor row/col.
REQ-008 SHALL have port board_player / board_pc  output  50 each  resolved boards for display.
REQ-009 SHALL have port player_ships / pc_ships  output  5 each  ships remaining.
REQ-010 SHALL have ports shot_hit, turn_done  output  1 each  one-cycle pulses.
REQ-011 SHALL have port time_expired  output  1  one-cycle pulse on turn timeout.
REQ-012 SHALL have port tick  input  1  one-cycle timebase pulse, 1 Hz.

Function
REQ-013 SHALL use cell codes EMPTY=00, SHIP=01, MISS=10, HIT=11.
REQ-014 SHALL implement states IDLE, WAIT_P, RES_P, PICK_PC, RES_PC, DONE.
REQ-015 SHALL go IDLE->WAIT_P when player_turn=1 and IDLE->PICK_PC when pc_turn=1, with player_turn taking priority.
REQ-016 SHALL, in WAIT_P, go to RES_P on a player_move rising edge when the cursor is in range (row,col <= 4); out-of-range fires are ignored.
REQ-017 SHALL, in RES_P, write SHIP->HIT (pulse shot_hit, decrement pc_ships) and EMPTY->MISS; an already-shot cell is left unchanged and the state returns to WAIT_P with no turn_done.
REQ-018 SHALL run a 5-bit LFSR (x^5+x^3+1, seed 00001) every clk cycle.
REQ-019 SHALL, on PICK_PC entry, set idx = lfsr if lfsr<25, else lfsr-25.
REQ-020 SHALL, in PICK_PC, advance idx by one per cycle (mod 25) while the player-board cell at idx is MISS/HIT, giving at most 25 probes.
REQ-021 SHALL, if all 25 probes find shot cells, go to DONE without a shot.
REQ-022 SHALL, in RES_PC, resolve the cell per REQ-017 against board_player/player_ships.
REQ-023 SHALL pulse turn_done for one cycle in DONE, then wait in DONE until both turn inputs are 0 before returning to IDLE.
REQ-024 SHALL saturate ship counters at 0 with no wrap.
REQ-025 SHALL, on load, take effect in any state, copy both boards, set each counter to its SHIP-cell count (0..25) and force IDLE.
REQ-026 SHALL keep fire latency at 2 cycles: edge -> RES_P -> updated board and turn_done visible.

Reset
REQ-027 SHALL, on rst low, immediately clear boards to all EMPTY, counters to 0, pulses to 0, state to IDLE, LFSR to 00001 and the edge-detect register to 0.
REQ-028 SHALL discard any in-flight shot when reset asserts mid-turn.

Configuration
REQ-029 SHALL provide macro TURN_TIMEOUT_EN.
REQ-030 SHALL, when TURN_TIMEOUT_EN is defined, fire at the current cursor after 10 ticks in WAIT_P with no fire (or at cell 0 if the cursor is out of range) and pulse time_expired alongside that fire; the tick count clears on entering WAIT_P.
REQ-031 SHALL, when TURN_TIMEOUT_EN is undefined, wait indefinitely in WAIT_P, tie time_expired to 0 and ignore tick.

Structure
REQ-032 SHALL place the cell-code enum, the state enum, the constants BOARD_N=5, CELLS=25 and TIMEOUT_TICKS=10, and the LFSR taps in a shared package battleship_pkg.
REQ-033 SHALL implement the SHIP-cell counter as sub-module ship_counter (50-bit board in, 5-bit count out, combinational).

Verification
REQ-034 SHALL cover: load with a pc board holding SHIP at cell 7, cursor (1,2), player_turn=1, player_move edge -> cell 7=HIT, shot_hit pulse, pc_ships 1->0, turn_done at edge+2.
REQ-035 SHALL cover: a fire on a MISS cell -> no board change, no turn_done, remains WAIT_P; then a fire on an EMPTY cell -> MISS and turn_done.
REQ-036 SHALL cover: pc_turn with the LFSR forced to 27 and cells 2,3 already shot -> shot lands on cell 4 after 3 probes.
REQ-037 SHALL cover: player board all MISS, pc_turn -> turn_done within 27 cycles with no change.
REQ-038 SHALL cover: rst low during RES_PC -> boards EMPTY, counters 0, state IDLE, no turn_done.
REQ-039 SHALL cover: with TURN_TIMEOUT_EN, 10 ticks with no fire and cursor (0,0) -> cell 0 resolved, time_expired and turn_done pulses.
